axis_div_operand_joiner: RTL and testbench
==========================================

AXIS_DIV_OPERAND_JOINER -- requirements
Module: axis_div_operand_joiner

Interface
REQ-001 SHALL have parameter DIVIDEND_WIDTH, default 5, dividend bit width.
REQ-002 SHALL have parameter DIVISOR_WIDTH, default 3, divisor bit width.
REQ-003 SHALL have parameter FLAG_WIDTH, default 10, sideband flag width.
REQ-004 SHALL have parameter DROP_DIVZERO, default 0; when 1, pairs with a zero divisor are consumed and not emitted.
REQ-005 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  reset; asynchronous assertion, active-low (0 = reset).
REQ-007 SHALL have port axis_in_dividend_data  input  DIVIDEND_WIDTH  dividend operand.
REQ-008 SHALL have port axis_in_dividend_flags  input  FLAG_WIDTH  flags travelling with the dividend.
REQ-009 SHALL have port axis_in_dividend_valid  input  1 and axis_in_dividend_ready  output  1  dividend handshake.
REQ-010 SHALL have port axis_in_divisor_data  input  DIVISOR_WIDTH  divisor operand.
REQ-011 SHALL have port axis_in_divisor_valid  input  1 and axis_in_divisor_ready  output  1  divisor handshake.
REQ-012 SHALL have ports axis_out_dividend (DIVIDEND_WIDTH), axis_out_divisor (DIVISOR_WIDTH), axis_out_flags (FLAG_WIDTH)  output  joined pair; matches the integer divider's input stream.
REQ-013 SHALL have ports axis_out_valid  output  1 and axis_out_ready  input  1  output handshake.
REQ-014 SHALL have port axis_out_divzero  output  1  high when the emitted divisor is 0.
REQ-015 SHALL have port pair_count  output  16  number of pairs emitted, wrapping.
REQ-016 SHALL have port divzero_count  output  16  number of zero-divisor pairs consumed, wrapping.

Function
REQ-017 SHALL perform a join (consume both inputs in the same cycle) only when both input valids are high and the buffer is not full.
REQ-018 SHALL drive axis_in_dividend_ready = axis_in_divisor_valid AND NOT full, and axis_in_divisor_ready = axis_in_dividend_valid AND NOT full; neither ready depends on axis_out_ready.
REQ-019 SHALL never consume one input without the other; a lone valid waits indefinitely with data held by the source.
REQ-020 SHALL hold joined pairs in a 2-entry FIFO with states EMPTY, ONE, FULL; join-only moves EMPTY->ONE->FULL, pop-only moves FULL->ONE->EMPTY, simultaneous join and pop keeps the state.
REQ-021 SHALL assert full only in state FULL; a join and a pop in the same cycle in state ONE preserves order and sustains one pair per cycle.
REQ-022 SHALL present a joined pair on the output one cycle after its join handshake (latency 1), axis_out_valid high in states ONE and FULL.
REQ-023 SHALL keep output data and axis_out_valid stable while axis_out_valid=1 and axis_out_ready=0.
REQ-024 SHALL compute axis_out_divzero at join time as (axis_in_divisor_data == 0) and store it with the entry.
REQ-025 SHALL, when DROP_DIVZERO=1, still complete both input handshakes for a zero-divisor pair but write no FIFO entry.
REQ-026 SHALL increment divzero_count on every consumed zero-divisor pair, for either DROP_DIVZERO setting.
REQ-027 SHALL increment pair_count on each output handshake (valid AND ready).
REQ-028 SHALL wrap both counters from 16'hFFFF to 0 without saturation or side effects.

Reset
REQ-029 SHALL, while rst=0, force FIFO state EMPTY, axis_out_valid=0, both input readys=0, axis_out_divzero=0, and pair_count=divzero_count=0; data outputs SHALL be 0.
REQ-030 SHALL discard buffered entries on mid-operation reset and accept the first join in the first cycle after rst returns to 1.

Structure
REQ-031 SHALL place the FIFO state enumeration (EMPTY, ONE, FULL) and the counter width constant (16) in the shared axis package.
REQ-032 SHALL instantiate one sub-module, axis_skid_fifo2, holding the 2-entry buffer; the join and counter logic SHALL stay in the top level.

Verification
REQ-033 Both inputs valid every cycle, dividend 1,2,3..., divisor 1,2,3..., out_ready=1 -> one pair per cycle, first output 1/1 one cycle after the first join, pair_count increments each cycle.
REQ-034 Dividend valid only, divisor valid 3 cycles later -> no consumption for 3 cycles, both handshakes in the same cycle, output one cycle later.
REQ-035 out_ready=0 for 5 cycles, inputs always valid -> exactly 2 joins, then both readys 0; after out_ready=1 the outputs appear in order with no loss or duplication.
REQ-036 Divisor 0 with dividend 17 at DROP_DIVZERO=0 -> output 17/0 with divzero=1, divzero_count=1; at DROP_DIVZERO=1 -> no output, divzero_count=1, pair_count unchanged.
REQ-037 rst driven to 0 with FIFO FULL -> valid and readys 0 immediately, counters 0; after release the next pair is emitted with latency 1.
REQ-038 65537 output handshakes -> pair_count reads 1.

Source files
------------

// File: rtl/axis_div_operand_joiner_pkg.sv
// Shared definitions for the divider operand joiner: buffer state encoding and
// the width of the statistics counters.
package axis_div_operand_joiner_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } fifo_state_e;

    localparam int unsigned CNT_W = 16;

endpackage

// File: rtl/axis_skid_fifo2.sv
// Two-entry buffer whose head register directly drives the output, so a pair
// written this cycle is visible next cycle and a push+pop in ONE sustains throughput.
module axis_skid_fifo2
    import axis_div_operand_joiner_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o,
    output logic         valid_o,
    output logic         full_o
);

    fifo_state_e  state_q;
    logic [W-1:0] head_q;
    logic [W-1:0] tail_q;

    // The caller never pushes in FULL, so FULL only has to handle pop.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push_i) begin
                        head_q  <= data_i;
                        state_q <= ONE;
                    end
                end
                ONE: begin
                    if (push_i && pop_i) begin
                        head_q <= data_i;
                    end else if (push_i) begin
                        tail_q  <= data_i;
                        state_q <= FULL;
                    end else if (pop_i) begin
                        state_q <= EMPTY;
                    end
                end
                FULL: begin
                    if (pop_i) begin
                        head_q  <= tail_q;
                        state_q <= ONE;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    assign data_o  = head_q;
    assign valid_o = (state_q != EMPTY);
    assign full_o  = (state_q == FULL);

endmodule

// File: rtl/axis_div_operand_joiner.sv
// Joins a dividend stream and a divisor stream into one pair stream for the
// integer divider, flagging (and optionally dropping) divide-by-zero pairs.
module axis_div_operand_joiner
    import axis_div_operand_joiner_pkg::*;
#(
    parameter int DIVIDEND_WIDTH = 5,
    parameter int DIVISOR_WIDTH  = 3,
    parameter int FLAG_WIDTH     = 10,
    parameter int DROP_DIVZERO   = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DIVIDEND_WIDTH-1:0] axis_in_dividend_data,
    input  logic [FLAG_WIDTH-1:0]     axis_in_dividend_flags,
    input  logic                      axis_in_dividend_valid,
    output logic                      axis_in_dividend_ready,
    input  logic [DIVISOR_WIDTH-1:0]  axis_in_divisor_data,
    input  logic                      axis_in_divisor_valid,
    output logic                      axis_in_divisor_ready,
    output logic [DIVIDEND_WIDTH-1:0] axis_out_dividend,
    output logic [DIVISOR_WIDTH-1:0]  axis_out_divisor,
    output logic [FLAG_WIDTH-1:0]     axis_out_flags,
    output logic                      axis_out_valid,
    input  logic                      axis_out_ready,
    output logic                      axis_out_divzero,
    output logic [CNT_W-1:0]          pair_count,
    output logic [CNT_W-1:0]          divzero_count
);

    localparam int ENTRY_W = 1 + FLAG_WIDTH + DIVISOR_WIDTH + DIVIDEND_WIDTH;
    localparam bit DROP    = (DROP_DIVZERO != 0);

    logic               full;
    logic               join_fire;
    logic               in_divzero;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] entry_in;
    logic [ENTRY_W-1:0] entry_out;
    logic [CNT_W-1:0]   pair_cnt_q,    pair_cnt_d;
    logic [CNT_W-1:0]   divzero_cnt_q, divzero_cnt_d;

    // Readys are gated by rst so they drop the instant reset asserts.
    assign axis_in_dividend_ready = rst && axis_in_divisor_valid  && !full;
    assign axis_in_divisor_ready  = rst && axis_in_dividend_valid && !full;

    assign join_fire  = axis_in_dividend_valid && axis_in_divisor_valid && !full;
    assign in_divzero = (axis_in_divisor_data == '0);
    assign push       = join_fire && !(DROP && in_divzero);
    assign pop        = axis_out_valid && axis_out_ready;
    assign entry_in   = {in_divzero, axis_in_dividend_flags, axis_in_divisor_data,
                         axis_in_dividend_data};

    axis_skid_fifo2 #(
        .W(ENTRY_W)
    ) u_fifo (
        .clk_i  (clk),
        .rst_n_i(rst),
        .push_i (push),
        .pop_i  (pop),
        .data_i (entry_in),
        .data_o (entry_out),
        .valid_o(axis_out_valid),
        .full_o (full)
    );

    assign {axis_out_divzero, axis_out_flags, axis_out_divisor, axis_out_dividend} = entry_out;

    always_comb begin
        pair_cnt_d    = pair_cnt_q;
        divzero_cnt_d = divzero_cnt_q;
        if (pop) begin
            pair_cnt_d = pair_cnt_q + CNT_W'(1);
        end
        if (join_fire && in_divzero) begin
            divzero_cnt_d = divzero_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pair_cnt_q    <= '0;
            divzero_cnt_q <= '0;
        end else begin
            pair_cnt_q    <= pair_cnt_d;
            divzero_cnt_q <= divzero_cnt_d;
        end
    end

    assign pair_count    = pair_cnt_q;
    assign divzero_count = divzero_cnt_q;

endmodule

// File: tb/tb_axis_div_operand_joiner.sv
// Directed bench for the operand joiner: one instance keeps zero-divisor pairs,
// a second instance on the same inputs drops them.
module tb_axis_div_operand_joiner;

    localparam int DW = 5;
    localparam int SW = 3;
    localparam int FW = 10;

    logic          clk;
    logic          rst;
    logic [DW-1:0] dvd_data;
    logic [FW-1:0] dvd_flags;
    logic          dvd_valid;
    logic [SW-1:0] dvs_data;
    logic          dvs_valid;
    logic          out_ready;

    logic          d0_dvd_ready, d0_dvs_ready, d0_out_valid, d0_divzero;
    logic [DW-1:0] d0_out_dividend;
    logic [SW-1:0] d0_out_divisor;
    logic [FW-1:0] d0_out_flags;
    logic [15:0]   d0_pair_count, d0_divzero_count;

    logic          d1_dvd_ready, d1_dvs_ready, d1_out_valid, d1_divzero;
    logic [DW-1:0] d1_out_dividend;
    logic [SW-1:0] d1_out_divisor;
    logic [FW-1:0] d1_out_flags;
    logic [15:0]   d1_pair_count, d1_divzero_count;

    int checks = 0;
    int errors = 0;

    axis_div_operand_joiner #(
        .DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(SW), .FLAG_WIDTH(FW), .DROP_DIVZERO(0)
    ) dut0 (
        .clk(clk), .rst(rst),
        .axis_in_dividend_data(dvd_data), .axis_in_dividend_flags(dvd_flags),
        .axis_in_dividend_valid(dvd_valid), .axis_in_dividend_ready(d0_dvd_ready),
        .axis_in_divisor_data(dvs_data), .axis_in_divisor_valid(dvs_valid),
        .axis_in_divisor_ready(d0_dvs_ready),
        .axis_out_dividend(d0_out_dividend), .axis_out_divisor(d0_out_divisor),
        .axis_out_flags(d0_out_flags), .axis_out_valid(d0_out_valid),
        .axis_out_ready(out_ready), .axis_out_divzero(d0_divzero),
        .pair_count(d0_pair_count), .divzero_count(d0_divzero_count)
    );

    axis_div_operand_joiner #(
        .DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(SW), .FLAG_WIDTH(FW), .DROP_DIVZERO(1)
    ) dut1 (
        .clk(clk), .rst(rst),
        .axis_in_dividend_data(dvd_data), .axis_in_dividend_flags(dvd_flags),
        .axis_in_dividend_valid(dvd_valid), .axis_in_dividend_ready(d1_dvd_ready),
        .axis_in_divisor_data(dvs_data), .axis_in_divisor_valid(dvs_valid),
        .axis_in_divisor_ready(d1_dvs_ready),
        .axis_out_dividend(d1_out_dividend), .axis_out_divisor(d1_out_divisor),
        .axis_out_flags(d1_out_flags), .axis_out_valid(d1_out_valid),
        .axis_out_ready(out_ready), .axis_out_divzero(d1_divzero),
        .pair_count(d1_pair_count), .divzero_count(d1_divzero_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int dvd, input int dvs, input int flg, input logic v_dvd,
                         input logic v_dvs);
        dvd_data  = DW'(dvd);
        dvs_data  = SW'(dvs);
        dvd_flags = FW'(flg);
        dvd_valid = v_dvd;
        dvs_valid = v_dvs;
    endtask

    task automatic reset_pulse();
        rst = 1'b0;
        drive(0, 0, 0, 1'b0, 1'b0);
        step();
        step();
        rst = 1'b1;
    endtask

    int  src;
    int  exp_out;
    logic jn;

    initial begin
        rst       = 1'b0;
        out_ready = 1'b0;
        drive(0, 0, 0, 1'b1, 1'b1);

        // Reset state, with both valids high to show the readys stay low.
        @(negedge clk);
        check("rst_out_valid", 32'(d0_out_valid), 32'd0);
        check("rst_dvd_ready", 32'(d0_dvd_ready), 32'd0);
        check("rst_dvs_ready", 32'(d0_dvs_ready), 32'd0);
        check("rst_divzero",   32'(d0_divzero), 32'd0);
        check("rst_pair_cnt",  32'(d0_pair_count), 32'd0);
        check("rst_dz_cnt",    32'(d0_divzero_count), 32'd0);
        check("rst_dividend",  32'(d0_out_dividend), 32'd0);
        step();
        drive(0, 0, 0, 1'b0, 1'b0);
        rst = 1'b1;

        // Streaming: one pair per cycle, latency 1.
        out_ready = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            drive(i, i, i * 3, 1'b1, 1'b1);
            @(negedge clk);
            check("t1_readys", 32'(d0_dvd_ready & d0_dvs_ready), 32'd1);
            if (i > 1) begin
                check("t1_valid",    32'(d0_out_valid), 32'd1);
                check("t1_dividend", 32'(d0_out_dividend), 32'(i - 1));
                check("t1_divisor",  32'(d0_out_divisor), 32'(i - 1));
                check("t1_flags",    32'(d0_out_flags), 32'((i - 1) * 3));
                check("t1_pair_cnt", 32'(d0_pair_count), 32'(i - 2));
            end
            step();
        end
        drive(0, 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        check("t1_last_div", 32'(d0_out_dividend), 32'd6);
        check("t1_last_cnt", 32'(d0_pair_count), 32'd5);
        step();
        @(negedge clk);
        check("t1_drained", 32'(d0_out_valid), 32'd0);
        check("t1_final_cnt", 32'(d0_pair_count), 32'd6);

        // Lone dividend waits three cycles for its divisor.
        step();
        drive(9, 5, 1, 1'b1, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("t2_dvd_ready", 32'(d0_dvd_ready), 32'd0);
            check("t2_no_out",    32'(d0_out_valid), 32'd0);
            step();
        end
        dvs_valid = 1'b1;
        @(negedge clk);
        check("t2_join", 32'(d0_dvd_ready & d0_dvs_ready), 32'd1);
        step();
        drive(0, 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        check("t2_valid",    32'(d0_out_valid), 32'd1);
        check("t2_dividend", 32'(d0_out_dividend), 32'd9);
        check("t2_divisor",  32'(d0_out_divisor), 32'd5);
        check("t2_divzero",  32'(d0_divzero), 32'd0);
        step();
        @(negedge clk);
        check("t2_pair_cnt", 32'(d0_pair_count), 32'd7);

        // Backpressure: two joins fill the buffer, then order is preserved.
        step();
        src     = 10;
        exp_out = 10;
        for (int cyc = 0; cyc < 16; cyc++) begin
            if (cyc < 12) drive(src, (src % 7) + 1, src, 1'b1, 1'b1);
            else          drive(0, 0, 0, 1'b0, 1'b0);
            out_ready = (cyc >= 5);
            @(negedge clk);
            if (cyc < 5) begin
                check("t3_ready", 32'(d0_dvd_ready), 32'(cyc < 2));
            end
            if (cyc >= 1 && cyc < 5) begin
                check("t3_hold_valid", 32'(d0_out_valid), 32'd1);
                check("t3_hold_data",  32'(d0_out_dividend), 32'd10);
            end
            jn = d0_dvd_ready && d0_dvs_ready;
            if (d0_out_valid && out_ready) begin
                check("t3_order_dvd", 32'(d0_out_dividend), 32'(exp_out));
                check("t3_order_dvs", 32'(d0_out_divisor), 32'((exp_out % 7) + 1));
                exp_out++;
            end
            step();
            if (jn) src++;
        end
        check("t3_joins",   32'(src), 32'd18);
        check("t3_no_loss", 32'(exp_out), 32'(src));
        @(negedge clk);
        check("t3_pair_cnt", 32'(d0_pair_count), 32'd15);

        // Zero divisor: kept and flagged by dut0, dropped by dut1.
        step();
        reset_pulse();
        out_ready = 1'b1;
        drive(17, 0, 'h2A, 1'b1, 1'b1);
        @(negedge clk);
        check("t4_d0_readys", 32'(d0_dvd_ready & d0_dvs_ready), 32'd1);
        check("t4_d1_readys", 32'(d1_dvd_ready & d1_dvs_ready), 32'd1);
        step();
        drive(0, 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        check("t4_d0_valid",    32'(d0_out_valid), 32'd1);
        check("t4_d0_dividend", 32'(d0_out_dividend), 32'd17);
        check("t4_d0_divisor",  32'(d0_out_divisor), 32'd0);
        check("t4_d0_flags",    32'(d0_out_flags), 32'h2A);
        check("t4_d0_divzero",  32'(d0_divzero), 32'd1);
        check("t4_d0_dz_cnt",   32'(d0_divzero_count), 32'd1);
        check("t4_d1_valid",    32'(d1_out_valid), 32'd0);
        check("t4_d1_dz_cnt",   32'(d1_divzero_count), 32'd1);
        step();
        @(negedge clk);
        check("t4_d0_pair_cnt", 32'(d0_pair_count), 32'd1);
        check("t4_d1_pair_cnt", 32'(d1_pair_count), 32'd0);

        // Asynchronous reset while the buffer is full.
        step();
        out_ready = 1'b0;
        drive(3, 3, 0, 1'b1, 1'b1);
        step();
        drive(4, 4, 0, 1'b1, 1'b1);
        step();
        @(negedge clk);
        check("t5_full_ready", 32'(d0_dvd_ready | d0_dvs_ready), 32'd0);
        check("t5_full_valid", 32'(d0_out_valid), 32'd1);
        check("t5_pre_dz_cnt", 32'(d0_divzero_count), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        check("t5_rst_valid",    32'(d0_out_valid), 32'd0);
        check("t5_rst_readys",   32'(d0_dvd_ready | d0_dvs_ready), 32'd0);
        check("t5_rst_pair_cnt", 32'(d0_pair_count), 32'd0);
        check("t5_rst_dz_cnt",   32'(d0_divzero_count), 32'd0);
        check("t5_rst_dividend", 32'(d0_out_dividend), 32'd0);
        step();
        rst = 1'b1;
        out_ready = 1'b1;
        drive(6, 6, 0, 1'b1, 1'b1);
        @(negedge clk);
        check("t5_post_readys", 32'(d0_dvd_ready & d0_dvs_ready), 32'd1);
        check("t5_post_empty",  32'(d0_out_valid), 32'd0);
        step();
        drive(0, 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        check("t5_post_valid",    32'(d0_out_valid), 32'd1);
        check("t5_post_dividend", 32'(d0_out_dividend), 32'd6);
        check("t5_post_divisor",  32'(d0_out_divisor), 32'd6);
        step();
        @(negedge clk);
        check("t5_post_cnt", 32'(d0_pair_count), 32'd1);

        // 65537 output handshakes wrap pair_count to 1.
        step();
        reset_pulse();
        out_ready = 1'b1;
        drive(1, 1, 0, 1'b1, 1'b1);
        repeat (65538) @(posedge clk);
        #1;
        drive(0, 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        check("t6_wrap_d0", 32'(d0_pair_count), 32'd1);
        check("t6_wrap_d1", 32'(d1_pair_count), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
